// File: rtl/redun_mont_seq_if.sv
// Load/unload stream plus multiplier-side signals of redun_mont_seq.
// The slave modport is the sequencer's view. The master modport is the view
// of the host and multiplier side.
interface redun_mont_seq_if #(
  parameter int unsigned DAT_BITS = 1024,
  parameter int unsigned CH       = 1,
  parameter int unsigned CNT_BITS = 64
);
  localparam int unsigned CHW = (CH > 1) ? $clog2(CH) : 1;

  logic [DAT_BITS-1:0] i_dat;
  logic [CNT_BITS-1:0] i_iter;
  logic                i_mode;
  logic [DAT_BITS-1:0] i_b;
  logic                i_val;
  logic                o_rdy;
  logic [DAT_BITS-1:0] o_mul_a;
  logic [DAT_BITS-1:0] o_mul_b;
  logic                o_mul_val;
  logic [DAT_BITS-1:0] i_mul_dat;
  logic                i_mul_val;
  logic                i_mul_ovf;
  logic [DAT_BITS-1:0] o_dat;
  logic [CHW-1:0]      o_ch;
  logic                o_err;
  logic                o_val;
  logic                i_rdy;

  modport slave (
    input  i_dat, i_iter, i_mode, i_b, i_val, i_mul_dat, i_mul_val, i_mul_ovf, i_rdy,
    output o_rdy, o_mul_a, o_mul_b, o_mul_val, o_dat, o_ch, o_err, o_val
  );

  modport master (
    output i_dat, i_iter, i_mode, i_b, i_val, i_mul_dat, i_mul_val, i_mul_ovf, i_rdy,
    input  o_rdy, o_mul_a, o_mul_b, o_mul_val, o_dat, o_ch, o_err, o_val
  );
endinterface

// File: rtl/redun_mont_seq.sv
// Iteration sequencer for the Montgomery squaring datapath: loads CH values,
// runs T rounds of square / multiply-by-b through an external in-order
// multiplier with channels interleaved, then streams the results out.
module redun_mont_seq #(
  parameter int unsigned DAT_BITS = 1024,
  parameter int unsigned CH       = 1,
  parameter int unsigned CNT_BITS = 64
) (
  input logic             i_clk,
  input logic             i_rst,
  redun_mont_seq_if.slave bus
);

  localparam int unsigned    CHW  = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [CHW-1:0] LAST = CHW'(CH - 1);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]          state;
  logic                armed;
  logic [DAT_BITS-1:0] val [CH];
  logic [CNT_BITS-1:0] iter;
  logic [CNT_BITS-1:0] rnd;
  logic                mode;
  logic [DAT_BITS-1:0] opb;
  logic                err;
  logic [CHW-1:0]      ld_k;
  logic [CHW-1:0]      nxt;
  logic [CHW-1:0]      tag;
  logic [CHW-1:0]      och;
  logic [CH-1:0]       pend;

  logic load_acc;
  logic issue;
  logic ret;
  logic ret_last;
  logic out_acc;

  function automatic logic [CHW-1:0] wrap_inc(input logic [CHW-1:0] k);
    return (k == LAST) ? '0 : k + 1'b1;
  endfunction

  // Handshake qualifiers and the issue decision for this cycle.
  always_comb begin
    load_acc = (state == S_LOAD) && armed && bus.i_val;
    issue    = (state == S_RUN) && pend[nxt];
    ret      = (state == S_RUN) && bus.i_mul_val;
    ret_last = ret && (rnd == iter - 1'b1);
    out_acc  = (state == S_OUT) && bus.i_rdy;
  end

  // Output drive; everything is forced to zero outside its valid window.
  always_comb begin
    bus.o_rdy     = (state == S_LOAD) && armed;
    bus.o_mul_val = issue;
    bus.o_mul_a   = issue ? val[nxt] : '0;
    bus.o_mul_b   = issue ? (mode ? opb : val[nxt]) : '0;
    bus.o_val     = (state == S_OUT);
    bus.o_dat     = (state == S_OUT) ? val[och] : '0;
    bus.o_ch      = (state == S_OUT) ? och : '0;
    bus.o_err     = (state == S_OUT) ? err : 1'b0;
  end

  // Control state. A channel whose value is ready to go to the multiplier
  // has its pend bit set; a single pointer walks the channels in order, so
  // round-0 issue and early returns (latency below CH) share one issue slot
  // without ever colliding or reordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= S_LOAD;
      armed <= 1'b0;
      iter  <= '0;
      rnd   <= '0;
      mode  <= 1'b0;
      opb   <= '0;
      err   <= 1'b0;
      ld_k  <= '0;
      nxt   <= '0;
      tag   <= '0;
      och   <= '0;
      pend  <= '0;
    end else begin
      armed <= 1'b1;
      case (state)
        S_LOAD: begin
          if (load_acc) begin
            if (ld_k == '0) begin
              iter <= bus.i_iter;
              mode <= bus.i_mode;
              opb  <= bus.i_b;
              err  <= 1'b0;
            end
            ld_k <= wrap_inc(ld_k);
            if (ld_k == LAST) begin
              nxt  <= '0;
              tag  <= '0;
              rnd  <= '0;
              och  <= '0;
              pend <= '1;
              state <= ((((ld_k == '0) ? bus.i_iter : iter)) == '0) ? S_OUT : S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            pend[nxt] <= 1'b0;
            nxt       <= wrap_inc(nxt);
          end
          if (ret) begin
            tag <= wrap_inc(tag);
            if (bus.i_mul_ovf) err <= 1'b1;
            if (!ret_last) pend[tag] <= 1'b1;
            if (tag == LAST) begin
              if (ret_last) state <= S_OUT;
              else          rnd   <= rnd + 1'b1;
            end
          end
        end
        S_OUT: begin
          if (out_acc) begin
            och <= wrap_inc(och);
            if (och == LAST) state <= S_LOAD;
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Per-channel value store: written by loads, then by multiplier returns.
  always_ff @(posedge i_clk) begin
    if (load_acc)  val[ld_k] <= bus.i_dat;
    else if (ret)  val[tag]  <= bus.i_mul_dat;
  end

endmodule

// File: tb/tb_redun_mont_seq.sv
// Bench for redun_mont_seq: one CH=1 and one CH=4 instance, each driving a
// (a*b) mod 65521 multiplier model of programmable latency.
module tb_redun_mont_seq;

  localparam int unsigned MODP = 65521;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [15:0] dat_in  [2];
  logic [15:0] iter_in [2];
  logic        mode_in [2];
  logic [15:0] b_in    [2];
  logic        val_in  [2];
  logic        rdy_in  [2];
  int unsigned lat     [2];
  int unsigned ovf_at  [2];

  wire         rdy_o   [2];
  wire  [15:0] mula_o  [2];
  wire  [15:0] mulb_o  [2];
  wire         mval_o  [2];
  wire  [15:0] dat_o   [2];
  wire  [7:0]  ch_o    [2];
  wire         err_o   [2];
  wire         val_o   [2];
  wire  [31:0] res_tot [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [15:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return 16'(p % MODP);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int unsigned NCH = (g == 0) ? 1 : 4;

    redun_mont_seq_if #(.DAT_BITS(16), .CH(NCH), .CNT_BITS(16)) bus ();

    redun_mont_seq #(.DAT_BITS(16), .CH(NCH), .CNT_BITS(16)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .bus  (bus.slave)
    );

    logic [15:0] m_dat = '0;
    logic        m_val = 1'b0;
    logic        m_ovf = 1'b0;
    int unsigned m_cyc = 0;
    int unsigned m_res = 0;
    int unsigned q_due [$];
    logic [15:0] q_dat [$];

    assign bus.i_dat     = dat_in[g];
    assign bus.i_iter    = iter_in[g];
    assign bus.i_mode    = mode_in[g];
    assign bus.i_b       = b_in[g];
    assign bus.i_val     = val_in[g];
    assign bus.i_rdy     = rdy_in[g];
    assign bus.i_mul_dat = m_dat;
    assign bus.i_mul_val = m_val;
    assign bus.i_mul_ovf = m_ovf;
    assign rdy_o[g]   = bus.o_rdy;
    assign mula_o[g]  = bus.o_mul_a;
    assign mulb_o[g]  = bus.o_mul_b;
    assign mval_o[g]  = bus.o_mul_val;
    assign dat_o[g]   = bus.o_dat;
    assign ch_o[g]    = 8'(bus.o_ch);
    assign err_o[g]   = bus.o_err;
    assign val_o[g]   = bus.o_val;
    assign res_tot[g] = m_res;

    // Multiplier model: an issue seen in cycle t returns its product in cycle t+lat.
    always @(negedge clk) begin
      m_val = 1'b0;
      m_ovf = 1'b0;
      m_dat = '0;
      if (rst) begin
        q_due.delete();
        q_dat.delete();
      end else begin
        m_cyc++;
        if (q_due.size() > 0 && q_due[0] == m_cyc) begin
          void'(q_due.pop_front());
          m_dat = q_dat.pop_front();
          m_val = 1'b1;
          m_res++;
          m_ovf = (ovf_at[g] != 0) && (m_res == ovf_at[g]);
        end
        if (bus.o_mul_val) begin
          q_due.push_back(m_cyc + lat[g]);
          q_dat.push_back(ref_mul(bus.o_mul_a, bus.o_mul_b));
        end
      end
    end
  end

  task automatic do_load(input int g, input int n, input logic [63:0] vp, input int t,
                         input logic md, input logic [15:0] bb);
    int w;
    for (int k = 0; k < n; k++) begin
      dat_in[g]  = vp[16*k +: 16];
      iter_in[g] = (k == 0) ? 16'(t) : 16'($urandom);
      mode_in[g] = (k == 0) ? md : 1'($urandom);
      b_in[g]    = (k == 0) ? bb : 16'($urandom);
      val_in[g]  = 1'b1;
      w = 0;
      while (!rdy_o[g] && w < 50) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (w >= 50) begin
        errors++;
        $display("FAIL load_rdy dut%0d word %0d: o_rdy stayed 0, required 1", g, k);
      end
      @(negedge clk);
    end
    val_in[g] = 1'b0;
  endtask

  // Load, run and unload one batch, checking issue order/operands, timing and results.
  task automatic run_case(input int g, input int n, input logic [63:0] vp, input int t,
                          input logic md, input logic [15:0] bb, input int l,
                          input bit ovf, input bit stall, input string nm);
    logic [15:0] cur [4];
    logic [15:0] exp_a [$];
    logic [15:0] ea;
    logic [15:0] eb;
    logic        exp_err;
    int cyc, issues, first_issues, w;

    lat[g]    = l;
    ovf_at[g] = ovf ? res_tot[g] + 2 : 0;
    exp_err   = ovf && (n * t >= 2);
    for (int k = 0; k < n; k++) cur[k] = vp[16*k +: 16];
    for (int r = 0; r < t; r++)
      for (int k = 0; k < n; k++) begin
        exp_a.push_back(cur[k]);
        cur[k] = ref_mul(cur[k], md ? bb : cur[k]);
      end

    do_load(g, n, vp, t, md, bb);
    rdy_in[g] = 1'b1;
    cyc = 1;
    issues = 0;
    first_issues = 0;
    while (!val_o[g] && cyc < 2000) begin
      if (mval_o[g]) begin
        issues++;
        if (cyc <= n) first_issues++;
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL %s extra_issue: o_mul_a=%0d at cycle %0d, required no issue", nm, mula_o[g], cyc);
        end else begin
          ea = exp_a.pop_front();
          eb = md ? bb : ea;
          if (mula_o[g] !== ea || mulb_o[g] !== eb) begin
            errors++;
            $display("FAIL %s issue_operands: a=%0d b=%0d, required a=%0d b=%0d", nm, mula_o[g], mulb_o[g], ea, eb);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!val_o[g]) begin
      errors++;
      $display("FAIL %s oval_timeout: o_val=0 after %0d cycles, required 1", nm, cyc);
    end
    checks++;
    if (issues != n * t) begin
      errors++;
      $display("FAIL %s issue_count: %0d, required %0d", nm, issues, n * t);
    end
    checks++;
    if (first_issues != ((t > 0) ? n : 0)) begin
      errors++;
      $display("FAIL %s first_issue_burst: %0d, required %0d", nm, first_issues, (t > 0) ? n : 0);
    end
    if (t == 0 || l >= n) begin
      checks++;
      if (cyc != ((t == 0) ? 1 : n + t * (l + 1))) begin
        errors++;
        $display("FAIL %s oval_latency: %0d, required %0d", nm, cyc, (t == 0) ? 1 : n + t * (l + 1));
      end
    end

    for (int k = 0; k < n; k++) begin
      w = 0;
      while (!val_o[g] && w < 10) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (dat_o[g] !== cur[k] || ch_o[g] !== 8'(k) || val_o[g] !== 1'b1) begin
        errors++;
        $display("FAIL %s out_word%0d: val=%0b dat=%0d ch=%0d, required val=1 dat=%0d ch=%0d",
                 nm, k, val_o[g], dat_o[g], ch_o[g], cur[k], k);
      end
      checks++;
      if (err_o[g] !== exp_err) begin
        errors++;
        $display("FAIL %s out_err%0d: %0b, required %0b", nm, k, err_o[g], exp_err);
      end
      if (k > 0) begin
        checks++;
        if (w != 0) begin
          errors++;
          $display("FAIL %s out_gap%0d: %0d idle cycles, required 0", nm, k, w);
        end
      end
      if (stall && k == 1) begin
        rdy_in[g] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (val_o[g] !== 1'b1 || dat_o[g] !== cur[k] || ch_o[g] !== 8'(k)) begin
            errors++;
            $display("FAIL %s stall_hold: val=%0b dat=%0d ch=%0d, required val=1 dat=%0d ch=%0d",
                     nm, val_o[g], dat_o[g], ch_o[g], cur[k], k);
          end
        end
        rdy_in[g] = 1'b1;
      end
      @(negedge clk);
    end
    rdy_in[g] = 1'b0;
    checks++;
    if (rdy_o[g] !== 1'b1 || val_o[g] !== 1'b0) begin
      errors++;
      $display("FAIL %s back_to_load: o_rdy=%0b o_val=%0b, required o_rdy=1 o_val=0", nm, rdy_o[g], val_o[g]);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({rdy_o[g], mval_o[g], val_o[g], err_o[g], dat_o[g], ch_o[g], mula_o[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: rdy=%0b mval=%0b val=%0b err=%0b dat=%0d ch=%0d, required all 0",
                 g, rdy_o[g], mval_o[g], val_o[g], err_o[g], dat_o[g], ch_o[g]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (rdy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy: o_rdy=%0b before first edge, required 0", rdy_o[0]);
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (rdy_o[g] !== 1'b1 || val_o[g] !== 1'b0) begin
        errors++;
        $display("FAIL reset_rdy dut%0d: o_rdy=%0b o_val=%0b, required 1 and 0", g, rdy_o[g], val_o[g]);
      end
    end
  endtask

  task automatic test_square();
    run_case(0, 1, 64'd2, 3, 1'b0, 16'd0, 4, 1'b0, 1'b0, "square_t3");
    run_case(0, 1, 64'd2, 5, 1'b0, 16'd0, 4, 1'b0, 1'b0, "square_t5");
  endtask

  task automatic test_multiply();
    run_case(0, 1, 64'd3, 4, 1'b1, 16'd2, 4, 1'b0, 1'b0, "multiply_b2");
  endtask

  task automatic test_interleave();
    run_case(1, 4, {16'd7, 16'd5, 16'd3, 16'd2}, 1, 1'b0, 16'd0, 4, 1'b0, 1'b0, "interleave_l4");
    run_case(1, 4, {16'd7, 16'd5, 16'd3, 16'd2}, 1, 1'b0, 16'd0, 2, 1'b0, 1'b0, "interleave_l2");
    run_case(1, 4, {16'd7, 16'd5, 16'd3, 16'd2}, 3, 1'b1, 16'd9, 2, 1'b0, 1'b0, "interleave_l2_t3");
  endtask

  task automatic test_zero_iter();
    run_case(0, 1, 64'd1234, 0, 1'b0, 16'd0, 4, 1'b0, 1'b0, "zero_iter_ch1");
    run_case(1, 4, {16'd40000, 16'd11, 16'd65535, 16'd9}, 0, 1'b1, 16'd5, 4, 1'b0, 1'b0, "zero_iter_ch4");
  endtask

  task automatic test_overflow_backpressure();
    run_case(1, 4, {16'd13, 16'd12, 16'd11, 16'd10}, 2, 1'b0, 16'd0, 4, 1'b1, 1'b1, "ovf_stall");
    run_case(1, 4, {16'd23, 16'd22, 16'd21, 16'd20}, 1, 1'b0, 16'd0, 4, 1'b0, 1'b0, "ovf_cleared");
  endtask

  task automatic test_reset_mid_run();
    int w;
    lat[0] = 4;
    ovf_at[0] = 0;
    do_load(0, 1, 64'd2, 5, 1'b0, 16'd0);
    w = 0;
    while (!mval_o[0] && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (mval_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_issue: o_mul_val=%0b, required 1 before reset", mval_o[0]);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mval_o[0] !== 1'b0 || val_o[0] !== 1'b0 || rdy_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_async: mval=%0b val=%0b rdy=%0b, required 0 0 0", mval_o[0], val_o[0], rdy_o[0]);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy_o[0] !== 1'b1 || mval_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrun_release: rdy=%0b mval=%0b, required 1 0", rdy_o[0], mval_o[0]);
    end
    run_case(0, 1, 64'd2, 3, 1'b0, 16'd0, 4, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int g, n, t, l;
    for (int i = 0; i < 8; i++) begin
      g = int'($urandom_range(0, 1));
      n = (g == 0) ? 1 : 4;
      t = int'($urandom_range(0, 4));
      l = int'($urandom_range(1, 6));
      run_case(g, n, {$urandom, $urandom}, t, 1'($urandom), 16'($urandom), l,
               1'($urandom), 1'($urandom), $sformatf("random%0d", i));
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      dat_in[g] = '0; iter_in[g] = '0; mode_in[g] = 1'b0; b_in[g] = '0;
      val_in[g] = 1'b0; rdy_in[g] = 1'b0; lat[g] = 4; ovf_at[g] = 0;
    end
    test_reset();
    test_square();
    test_multiply();
    test_interleave();
    test_zero_iter();
    test_overflow_backpressure();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
